// File: rtl/xcorr_lag_pkg.sv
// Shared definitions for the lag-search block: FSM encodings and the
// window/width derivations reused by later estimation stages.
package xcorr_lag_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int calc_w(input int ndata, input int maxlag);
      return ndata - maxlag;
   endfunction

   function automatic int calc_lag_w(input int maxlag);
      return $clog2(maxlag + 1);
   endfunction

   function automatic int calc_score_w(input int ndata, input int maxlag);
      return $clog2(ndata - maxlag + 1);
   endfunction

   function automatic int calc_i_w(input int ndata, input int maxlag);
      return ((ndata - maxlag) > 1) ? $clog2(ndata - maxlag) : 1;
   endfunction

endpackage

// File: rtl/xcorr_lag_channel.sv
// One correlation channel: per-lag match accumulator plus the running best
// score and the lag at which it was reached.
module xcorr_channel #(
   parameter int LAG_W   = 6,
   parameter int SCORE_W = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               bit_match,
   input  logic               last_bit,
   input  logic [LAG_W-1:0]   k,
   output logic [SCORE_W-1:0] best_score,
   output logic [LAG_W-1:0]   best_lag
);

   logic [SCORE_W-1:0] acc;
   logic [SCORE_W-1:0] score_now;

   assign score_now = acc + SCORE_W'(bit_match);

   // strict compare: on a tie the earlier (smaller) lag is kept
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc        <= '0;
         best_score <= '0;
         best_lag   <= '0;
      end else if (last_bit) begin
         acc <= '0;
         if (score_now > best_score) begin
            best_score <= score_now;
            best_lag   <= k;
         end
      end else begin
         acc <= score_now;
      end
   end

endmodule

// File: rtl/xcorr_lag.sv
// Bit-serial cross-correlation lag search over three channels against one
// reference. Optional best-score outputs are enabled by XCORR_SCORE_EN.
//
// state | meaning
// IDLE  | waiting for start; captures vectors on start
// RUN   | one compared bit per cycle per channel, lags 0..MAXLAG
// DONE  | one-cycle done pulse, results copied to outputs
module xcorr_lag
   import xcorr_lag_pkg::*;
#(
   parameter  int NDATA   = 128,
   parameter  int MAXLAG  = 32,
   localparam int W       = calc_w(NDATA, MAXLAG),
   localparam int LAG_W   = calc_lag_w(MAXLAG),
   localparam int SCORE_W = calc_score_w(NDATA, MAXLAG)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [NDATA-1:0]   dinRef,
   input  logic [NDATA-1:0]   dinSigA,
   input  logic [NDATA-1:0]   dinSigB,
   input  logic [NDATA-1:0]   dinSigC,
   output logic               busy,
   output logic               done,
`ifdef XCORR_SCORE_EN
   output logic [SCORE_W-1:0] scoreA,
   output logic [SCORE_W-1:0] scoreB,
   output logic [SCORE_W-1:0] scoreC,
`endif
   output logic [LAG_W-1:0]   lagA,
   output logic [LAG_W-1:0]   lagB,
   output logic [LAG_W-1:0]   lagC
);

   localparam int IW    = calc_i_w(NDATA, MAXLAG);
   localparam int IDX_W = (NDATA > 1) ? $clog2(NDATA) : 1;

   logic [1:0]         state;
   logic [NDATA-1:0]   ref_q, siga_q, sigb_q, sigc_q;
   logic [IW-1:0]      i_q;
   logic [LAG_W-1:0]   k_q;
   logic               run, capture, last_bit;
   logic [IDX_W-1:0]   idx_ref, idx_sig;
   logic               match_a, match_b, match_c;
   logic [LAG_W-1:0]   best_lag_a, best_lag_b, best_lag_c;
   logic [SCORE_W-1:0] best_score_a, best_score_b, best_score_c;

   assign run      = (state == ST_RUN);
   assign capture  = (state == ST_IDLE) && start;
   assign last_bit = run && (i_q == IW'(W - 1));
   assign busy     = run;
   assign done     = (state == ST_DONE);

   // i + k never exceeds NDATA-1 because i < W = NDATA - MAXLAG
   assign idx_ref = IDX_W'(i_q);
   assign idx_sig = IDX_W'(i_q) + IDX_W'(k_q);

   assign match_a = run && (ref_q[idx_ref] ~^ siga_q[idx_sig]);
   assign match_b = run && (ref_q[idx_ref] ~^ sigb_q[idx_sig]);
   assign match_c = run && (ref_q[idx_ref] ~^ sigc_q[idx_sig]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         ref_q  <= '0;
         siga_q <= '0;
         sigb_q <= '0;
         sigc_q <= '0;
         i_q    <= '0;
         k_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ref_q  <= dinRef;
                  siga_q <= dinSigA;
                  sigb_q <= dinSigB;
                  sigc_q <= dinSigC;
                  i_q    <= '0;
                  k_q    <= '0;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (last_bit) begin
                  i_q <= '0;
                  k_q <= k_q + 1'b1;
                  if (k_q == LAG_W'(MAXLAG))
                     state <= ST_DONE;
               end else begin
                  i_q <= i_q + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lagA <= '0;
         lagB <= '0;
         lagC <= '0;
      end else if (state == ST_DONE) begin
         lagA <= best_lag_a;
         lagB <= best_lag_b;
         lagC <= best_lag_c;
      end
   end

`ifdef XCORR_SCORE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         scoreA <= '0;
         scoreB <= '0;
         scoreC <= '0;
      end else if (state == ST_DONE) begin
         scoreA <= best_score_a;
         scoreB <= best_score_b;
         scoreC <= best_score_c;
      end
   end
`else
   // best scores only steer the lag choice inside each channel
   logic score_unused;
   assign score_unused = ^{best_score_a, best_score_b, best_score_c};
`endif

   xcorr_channel #(.LAG_W(LAG_W), .SCORE_W(SCORE_W)) u_ch_a (
      .clk(clk), .rst(rst), .clear(capture), .bit_match(match_a),
      .last_bit(last_bit), .k(k_q),
      .best_score(best_score_a), .best_lag(best_lag_a)
   );

   xcorr_channel #(.LAG_W(LAG_W), .SCORE_W(SCORE_W)) u_ch_b (
      .clk(clk), .rst(rst), .clear(capture), .bit_match(match_b),
      .last_bit(last_bit), .k(k_q),
      .best_score(best_score_b), .best_lag(best_lag_b)
   );

   xcorr_channel #(.LAG_W(LAG_W), .SCORE_W(SCORE_W)) u_ch_c (
      .clk(clk), .rst(rst), .clear(capture), .bit_match(match_c),
      .last_bit(last_bit), .k(k_q),
      .best_score(best_score_c), .best_lag(best_lag_c)
   );

endmodule

// File: tb/tb_xcorr_lag.sv
// Directed bench for xcorr_lag at NDATA=16, MAXLAG=4 (W=12, done at cycle 61).
// Score outputs are connected and checked when XCORR_SCORE_EN is defined.
module tb_xcorr_lag;

   localparam int NDATA    = 16;
   localparam int MAXLAG   = 4;
   localparam int DONE_CYC = 61;

   typedef struct {
      string       name;
      logic [15:0] r, a, b, c;
      int          la, lb, lc;
      int          sa, sb, sc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] dref, da, db, dc;
   logic        busy, done;
   logic [2:0]  lagA, lagB, lagC;
`ifdef XCORR_SCORE_EN
   logic [3:0]  scoreA, scoreB, scoreC;
`endif

   int n_pass  = 0;
   int n_total = 0;
   vec_t tbl[5];

   always #5 clk = ~clk;

   xcorr_lag #(.NDATA(NDATA), .MAXLAG(MAXLAG)) dut (
      .clk(clk), .rst(rst), .start(start),
      .dinRef(dref), .dinSigA(da), .dinSigB(db), .dinSigC(dc),
      .busy(busy), .done(done),
`ifdef XCORR_SCORE_EN
      .scoreA(scoreA), .scoreB(scoreB), .scoreC(scoreC),
`endif
      .lagA(lagA), .lagB(lagB), .lagC(lagC)
   );

   task automatic check(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic check_results(input vec_t v);
      check({v.name, " lagA"}, int'(lagA), v.la);
      check({v.name, " lagB"}, int'(lagB), v.lb);
      check({v.name, " lagC"}, int'(lagC), v.lc);
`ifdef XCORR_SCORE_EN
      check({v.name, " scoreA"}, int'(scoreA), v.sa);
      check({v.name, " scoreB"}, int'(scoreB), v.sb);
      check({v.name, " scoreC"}, int'(scoreC), v.sc);
`endif
   endtask

   // Launch a search, scramble the inputs right after capture, and time done.
   // restart_at > 0 pulses start again during RUN at that cycle.
   task automatic run_search(input vec_t v, input int restart_at);
      int done_at, busy_bad, extra_done;
      @(negedge clk);
      dref = v.r; da = v.a; db = v.b; dc = v.c; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dref = ~v.r; da = ~v.a; db = ~v.b; dc = ~v.c;
      done_at  = 0;
      busy_bad = 0;
      for (int n = 1; n <= 200 && done_at == 0; n++) begin
         @(negedge clk);
         start = (n == restart_at);
         if (done) done_at = n;
         else if (!busy) busy_bad++;
      end
      start = 1'b0;
      check({v.name, " done cycle"}, done_at, DONE_CYC);
      check({v.name, " busy gaps"}, busy_bad, 0);
      @(negedge clk);
      check({v.name, " done width"}, int'(done), 0);
      check({v.name, " busy after"}, int'(busy), 0);
      check_results(v);
      if (restart_at > 0) begin
         extra_done = 0;
         for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (done) extra_done++;
         end
         check({v.name, " extra done"}, extra_done, 0);
      end
   endtask

   initial begin
      int n_done;
      tbl[0] = '{"shift",   16'hB4E1, 16'hD384, 16'hB4E1, 16'h4E10, 2, 0, 4, 12, 12, 12};
      tbl[1] = '{"zeros",   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 12, 12, 12};
      tbl[2] = '{"alt",     16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 1, 0, 1, 12, 12, 12};
      tbl[3] = '{"ones",    16'hFFFF, 16'h0000, 16'hFFFF, 16'hF000, 0, 0, 4,  0, 12,  4};
      tbl[4] = '{"partial", 16'h0000, 16'h000F, 16'hFFF0, 16'h0F00, 4, 0, 0, 12,  4,  8};

      rst = 1'b1; start = 1'b0;
      dref = '0; da = '0; db = '0; dc = '0;
      repeat (2) @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset lagA", int'(lagA), 0);
      check("reset lagC", int'(lagC), 0);
      rst = 1'b0;

      for (int t = 0; t < 5; t++) run_search(tbl[t], 0);

      tbl[0].name = "restart";
      run_search(tbl[0], 10);

      // reset at cycle 30 of a search aborts it with no done pulse
      @(negedge clk);
      dref = tbl[2].r; da = tbl[2].a; db = tbl[2].b; dc = tbl[2].c; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 30; n++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort lagA", int'(lagA), 0);
      check("abort lagC", int'(lagC), 0);
      n_done = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("abort no done", n_done, 0);
      tbl[0].name = "after abort";
      run_search(tbl[0], 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/xcorr_lag.md
Name: xcorr_lag

Overview:
- Downstream consumer of the four-channel serial input buffer.
- Takes the reference vector and three signal vectors, each NDATA bits wide, and finds the lag at which each signal best matches the reference.
- Runs a bit-serial cross-correlation over lags 0..MAXLAG, one compared bit per cycle, with all three channels in parallel.
- Reports best lag per channel, which feeds the direction/delay estimation stage.

Parameters:
- NDATA, 128, width of each input vector; must match the buffer stage.
- MAXLAG, 32, largest lag searched; constraint 1 <= MAXLAG < NDATA.
- Derived localparam W = NDATA - MAXLAG, the compare window length, identical for every lag.
- Derived localparams: LAG_W = $clog2(MAXLAG+1), SCORE_W = $clog2(W+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a search; sampled only in IDLE
- dinRef  in  NDATA  reference vector
- dinSigA  in  NDATA  signal A vector
- dinSigB  in  NDATA  signal B vector
- dinSigC  in  NDATA  signal C vector
- busy  out  1  high while a search is in progress
- done  out  1  one-cycle pulse when results are updated
- lagA  out  LAG_W  best lag for signal A
- lagB  out  LAG_W  best lag for signal B
- lagC  out  LAG_W  best lag for signal C

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE; busy, done, lagA/B/C, and all internal counters, accumulators and best registers = 0.
- Score definition: score(k) = number of i in [0, W-1] with ref[i] == sig[i+k], for k in [0, MAXLAG].
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On start=1, capture all four vectors into internal registers; clear k, i, accumulators and best score/lag; go to RUN.
  - Inputs may change freely after the capture cycle.
- RUN:
  - busy=1.
  - Each cycle, every channel adds (ref_q[i] ~^ sig_q[i+k]) to its accumulator; then i increments.
  - At i == W-1, each channel evaluates its final score for lag k, including the current bit.
  - If that score > best (strict), best <= score and bestlag <= k. Ties therefore keep the smallest lag.
  - Also at i == W-1: accumulator <= 0, i <= 0, k <= k+1.
  - When k == MAXLAG and i == W-1: go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - lagA/B/C <= bestlag registers; go to IDLE.
- Result outputs hold their values until the next DONE or rst.
- Latency:
  - start accepted at cycle 0.
  - RUN occupies cycles 1..(MAXLAG+1)*W.
  - done is high at cycle (MAXLAG+1)*W + 1.
  - Next start is accepted in the cycle after done.
- start while in RUN or DONE is ignored; there is no queueing.
- rst mid-search aborts immediately: next cycle is IDLE, outputs cleared, no done pulse.
- Best-score initial value is 0. If every score is 0, lag = 0.
- Widths:
  - i counter is $clog2(W) bits, minimum 1.
  - k counter is LAG_W bits.
  - Accumulators are SCORE_W bits and cannot overflow, since max score = W.

Optional Feature:
- Macro: XCORR_SCORE_EN.
- Defined: adds outputs scoreA, scoreB, scoreC (each SCORE_W bits).
  - Updated together with lagA/B/C in DONE, holding the best score.
  - Reset value 0.
- Undefined: these ports do not exist; best-score registers stay internal.
- Lag behaviour is identical in both builds.

Decomposition:
- Shared header xcorr_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The W / LAG_W / SCORE_W derivation macros, for reuse by later estimation stages.
- Sub-module xcorr_channel, instantiated three times, contains:
  - the accumulator, the best-score register and the bestlag register;
  - inputs: clk, rst, clear, bit_match, last_bit, k.
- The top level owns the FSM, the i/k counters, input capture and bit selection.

Test Plan (NDATA=16, MAXLAG=4, so W=12, done at cycle 61):
- Shift match: ref=16'hB4E1, sigA[i+2]=ref[i] for all i, sigB=ref, sigC[i+4]=ref[i] -> lagA=2, lagB=0, lagC=4; score=12 with XCORR_SCORE_EN.
- Ties: all vectors 16'h0000 -> every lag scores 12 -> lagA=lagB=lagC=0; done exactly at cycle 61; busy high for cycles 1..60.
- Inverted alternating: ref=16'h5555, sigA=16'hAAAA -> lags 1 and 3 score 12, lags 0, 2 and 4 score 0 -> lagA=1.
- Start during RUN: second start pulse at cycle 10 -> ignored; single done at cycle 61; results match the first capture.
- Reset mid-search: rst at cycle 30 -> IDLE at cycle 31, lag outputs 0, no done pulse; a new start then completes normally 61 cycles later.
- Input change after capture: vectors altered at cycle 1 -> results reflect the values captured at cycle 0.
